// File: rtl/read_pointer_fwft.sv
// Read-domain pointer, empty/level flags and one-entry FWFT output register
// for the async FIFO read side.
module read_pointer_fwft #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  almost_empty
);

  localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] rbin;
  logic [PTR_WIDTH-1:0] rbin_next_c;
  logic [PTR_WIDTH-1:0] rgray_next_c;
  logic [PTR_WIDTH-1:0] wbin_c;
  logic [PTR_WIDTH-1:0] level_next_c;
  logic                 mem_rd_c;

  // Pop from RAM only when it holds data and the output slot is free or draining.
  assign mem_rd_c     = ~empty & (~dout_valid | dout_ready);
  assign rbin_next_c  = rbin + PTR_WIDTH'(mem_rd_c);
  assign rgray_next_c = (rbin_next_c >> 1) ^ rbin_next_c;
  assign raddr        = rbin[ADDR_WIDTH-1:0];
  assign level_next_c = wbin_c - rbin_next_c;

  // Gray-to-binary of the synchronized write pointer.
  always_comb begin
    wbin_c = '0;
    for (int i = 0; i < int'(PTR_WIDTH); i++) begin
      wbin_c[i] = ^(rq2_wptr >> i);
    end
  end

  // Read pointer (binary and Gray) and empty flag update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
    end else begin
      rbin  <= rbin_next_c;
      rptr  <= rgray_next_c;
      empty <= (rgray_next_c == rq2_wptr);
    end
  end

  // Fill level and almost-empty flag, both from the post-pop pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rlevel       <= '0;
      almost_empty <= 1'b1;
    end else begin
      rlevel       <= level_next_c;
      almost_empty <= (level_next_c <= PTR_WIDTH'(AE_THRESH));
    end
  end

  // FWFT output register: load on pop, drop valid when consumed, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (mem_rd_c) begin
      dout       <= rdata_mem;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_pointer_fwft.sv
// Self-checking bench for read_pointer_fwft (ADDR_WIDTH=4, RAM word i = 0xA0+i).
module tb_read_pointer_fwft;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic [AW:0]   rq2_wptr;
  logic [DW-1:0] rdata_mem;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          empty;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [AW:0]   rlevel;
  logic          almost_empty;

  int tests;
  int fails;

  read_pointer_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AE_THRESH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rq2_wptr(rq2_wptr), .rdata_mem(rdata_mem),
    .raddr(raddr), .rptr(rptr), .empty(empty), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .rlevel(rlevel),
    .almost_empty(almost_empty)
  );

  // RAM preloaded with mem[i] = 0xA0 + i, read combinationally.
  assign rdata_mem = 8'h A0 + {4'b0, raddr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: word counts as plain integers.
  int m_wcnt, m_rcnt, m_level, m_dout;
  bit m_dv, m_empty, m_ae;
  logic [AW:0] prev_rptr;

  function automatic logic [AW:0] gray5(input int n);
    logic [AW:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_rcnt = 0; m_level = 0; m_dout = 0;
    m_dv = 0; m_empty = 1; m_ae = 1;
    prev_rptr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq2_wptr = '0;
    dout_ready = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive inputs, advance one edge, settle.
  task automatic step(input int w, input bit r);
    m_wcnt = w;
    rq2_wptr = gray5(w);
    dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Advance the model over the edge just taken and compare every output.
  task automatic model_step();
    bit pop;
    pop = !m_empty && (!m_dv || dout_ready);
    if (pop) begin
      m_dout = 'h A0 + (m_rcnt % 16);
      m_dv = 1;
    end else if (dout_ready) begin
      m_dv = 0;
    end
    if (pop) m_rcnt++;
    m_level = m_wcnt - m_rcnt;
    m_empty = (m_level == 0);
    m_ae = (m_level <= 2);
    chk("empty", int'(empty), int'(m_empty));
    chk("rlevel", int'(rlevel), m_level);
    chk("dout_valid", int'(dout_valid), int'(m_dv));
    chk("dout", int'(dout), m_dout);
    chk("rptr", int'(rptr), int'(gray5(m_rcnt)));
    chk("raddr", int'(raddr), m_rcnt % 16);
    chk("almost_empty", int'(almost_empty), int'(m_ae));
    chk("rptr_one_bit", $countones(rptr ^ prev_rptr), int'(pop));
    prev_rptr = rptr;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_dv"}, int'(dout_valid), 0);
    chk({tag, "_rptr"}, int'(rptr), 0);
    chk({tag, "_raddr"}, int'(raddr), 0);
    chk({tag, "_rlevel"}, int'(rlevel), 0);
    chk({tag, "_ae"}, int'(almost_empty), 1);
    chk({tag, "_dout"}, int'(dout), 0);
  endtask

  typedef struct {
    bit rst; int wcnt; bit ready;
    int e_empty; int e_level; int e_dv; int e_dout; int e_rptr; int e_raddr; int e_ae;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit rst, input int w, input bit r, input int e, input int l,
                              input int dv, input int d, input int p, input int a, input int ae);
    vec_t v;
    v.rst = rst; v.wcnt = w; v.ready = r;
    v.e_empty = e; v.e_level = l; v.e_dv = dv; v.e_dout = d;
    v.e_rptr = p; v.e_raddr = a; v.e_ae = ae;
    return v;
  endfunction

  initial begin
    int got;
    bit seen_wrap;
    logic [AW-1:0] prev_raddr;
    vec_t v;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    rq2_wptr = '0;
    dout_ready = 1'b0;
    model_reset();

    // Reset values, then an asynchronous mid-clock reset from a non-reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    step(2, 0);
    step(2, 0);
    chk("pre_rst_dv", int'(dout_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");

    // Directed scenarios: single word, backpressure, almost-empty.
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 'h00, 'b00000, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 'hA0, 'b00001, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 'hA0, 'b00001, 1, 1));
    vecs.push_back(mk(1, 3, 0, 0, 3, 0, 'h00, 'b00000, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0, 2, 1, 'hA0, 'b00001, 1, 1));
    vecs.push_back(mk(0, 3, 0, 0, 2, 1, 'hA0, 'b00001, 1, 1));
    vecs.push_back(mk(0, 3, 1, 0, 1, 1, 'hA1, 'b00011, 2, 1));
    vecs.push_back(mk(0, 3, 1, 1, 0, 1, 'hA2, 'b00010, 3, 1));
    vecs.push_back(mk(0, 3, 1, 1, 0, 0, 'hA2, 'b00010, 3, 1));
    vecs.push_back(mk(1, 4, 0, 0, 4, 0, 'h00, 'b00000, 0, 0));
    vecs.push_back(mk(0, 4, 0, 0, 3, 1, 'hA0, 'b00001, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 3, 1, 'hA0, 'b00001, 1, 0));
    vecs.push_back(mk(0, 4, 1, 0, 2, 1, 'hA1, 'b00011, 2, 1));
    vecs.push_back(mk(0, 4, 0, 0, 2, 1, 'hA1, 'b00011, 2, 1));
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) do_reset();
      step(v.wcnt, v.ready);
      chk($sformatf("v%0d_empty", i), int'(empty), v.e_empty);
      chk($sformatf("v%0d_rlevel", i), int'(rlevel), v.e_level);
      chk($sformatf("v%0d_dv", i), int'(dout_valid), v.e_dv);
      chk($sformatf("v%0d_dout", i), int'(dout), v.e_dout);
      chk($sformatf("v%0d_rptr", i), int'(rptr), v.e_rptr);
      chk($sformatf("v%0d_raddr", i), int'(raddr), v.e_raddr);
      chk($sformatf("v%0d_ae", i), int'(almost_empty), v.e_ae);
    end

    // Wrap: stream 20 words through a 16-deep RAM.
    do_reset();
    got = 0;
    seen_wrap = 0;
    prev_raddr = '0;
    for (int c = 0; c < 60; c++) begin
      step((m_wcnt < 20) ? m_wcnt + 1 : m_wcnt, 1);
      model_step();
      if (dout_valid) begin
        chk("wrap_data", int'(dout), 'hA0 + (got % 16));
        got++;
      end
      if (prev_raddr == 4'd15 && raddr == 4'd0) begin
        seen_wrap = 1;
        chk("wrap_rptr", int'(rptr), 'b11000);
      end
      prev_raddr = raddr;
      if (got == 20 && empty && !dout_valid) break;
    end
    chk("wrap_count", got, 20);
    chk("wrap_seen", int'(seen_wrap), 1);
    chk("wrap_final_rptr", int'(rptr), 'b11110);
    chk("wrap_final_empty", int'(empty), 1);

    // Reset mid-stream with a held word and rlevel=5.
    do_reset();
    step(6, 0); model_step();
    step(6, 0); model_step();
    chk("mid_level", int'(rlevel), 5);
    chk("mid_dv", int'(dout_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(0, 1); model_step();
    end
    for (int c = 0; c < 3; c++) begin
      step(1, 1); model_step();
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int w;
      w = m_wcnt;
      if ($urandom_range(0, 2) != 0 && (w - m_rcnt) < 16) w++;
      step(w, 1'($urandom_range(0, 1)));
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
